// File: rtl/ghost_nav_scheduler.sv
// Time-multiplexed ghost direction scheduler: after each tick, ghosts are evaluated one per clk.
// Define GHOST_FRIGHT_MODE_EN to add the power-pellet FRIGHT mode with LFSR-driven moves.
module ghost_nav_scheduler #(
  parameter int NUM_GHOSTS    = 4,
  parameter int X_W           = 11,
  parameter int Y_W           = 10,
  parameter int X_MAX         = 639,
  parameter int Y_MAX         = 479,
  parameter int SCATTER_TICKS = 7,
  parameter int CHASE_TICKS   = 20,
  parameter int FRIGHT_TICKS  = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic [NUM_GHOSTS*X_W-1:0] ghost_pos_x,
  input  logic [NUM_GHOSTS*Y_W-1:0] ghost_pos_y,
  input  logic [X_W-1:0]            pacman_pos_x,
  input  logic [Y_W-1:0]            pacman_pos_y,
  input  logic [NUM_GHOSTS*4-1:0]   valid_moves,
  input  logic                      power_pellet,
  output logic [NUM_GHOSTS*4-1:0]   move_dir,
  output logic                      dir_valid,
  output logic [1:0]                mode,
  output logic                      overrun
);

  localparam int IW       = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
  localparam int D_W      = (X_W > Y_W) ? X_W : Y_W;
  localparam int T_MAX_SC = (SCATTER_TICKS > CHASE_TICKS) ? SCATTER_TICKS : CHASE_TICKS;
  localparam int T_MAX    = (T_MAX_SC > FRIGHT_TICKS) ? T_MAX_SC : FRIGHT_TICKS;
  localparam int TW       = $clog2(T_MAX + 1);

  localparam logic [3:0] DIR_R  = 4'b0001;
  localparam logic [3:0] DIR_U  = 4'b0010;
  localparam logic [3:0] DIR_D  = 4'b0100;
  localparam logic [3:0] DIR_L  = 4'b1000;
  localparam logic [3:0] H_MASK = DIR_R | DIR_L;
  localparam logic [3:0] V_MASK = DIR_U | DIR_D;
  localparam logic [IW-1:0] LAST = IW'(NUM_GHOSTS - 1);

  typedef enum logic [1:0] {
    MODE_SCATTER = 2'b00,
    MODE_CHASE   = 2'b01,
    MODE_FRIGHT  = 2'b10
  } mode_t;

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

  // Opposite direction: R<->L and U<->D is exactly a bit reversal of the encoding.
  function automatic logic [3:0] rev_dir(input logic [3:0] d);
    return {d[0], d[1], d[2], d[3]};
  endfunction

  function automatic logic [3:0] first_prio(input logic [3:0] m);
    if (m[0])      return DIR_R;
    else if (m[3]) return DIR_L;
    else if (m[1]) return DIR_U;
    else if (m[2]) return DIR_D;
    return 4'b0000;
  endfunction

  state_t         state, state_next;
  mode_t          mode_q, sweep_mode, mode_after;
  logic [IW-1:0]  idx;
  logic [TW-1:0]  timer, mode_limit;
  logic           sweep_start;

  logic [X_W-1:0] gx, tx;
  logic [Y_W-1:0] gy, ty;
  logic [D_W-1:0] dx, dy;
  logic [1:0]     corner;
  logic [3:0]     valid, prev, rev_prev, legal, toward, cand;
  logic [3:0]     normal_pick, dead_pick, pick;

  assign sweep_start = (state == S_IDLE) && tick;
  assign mode        = mode_q;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (tick) state_next = S_EVAL;
      S_EVAL:  if (idx == LAST) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Move selection for the ghost currently addressed by idx.
  always_comb begin
    gx       = ghost_pos_x[idx*X_W +: X_W];
    gy       = ghost_pos_y[idx*Y_W +: Y_W];
    valid    = valid_moves[idx*4 +: 4];
    prev     = move_dir[idx*4 +: 4];
    corner   = 2'(idx);
    tx       = corner[0] ? X_W'(X_MAX) : '0;
    ty       = corner[1] ? Y_W'(Y_MAX) : '0;
    if (sweep_mode == MODE_CHASE) begin
      tx = pacman_pos_x;
      ty = pacman_pos_y;
    end
    dx       = (tx > gx) ? D_W'(tx - gx) : D_W'(gx - tx);
    dy       = (ty > gy) ? D_W'(ty - gy) : D_W'(gy - ty);
    toward   = {tx < gx, ty > gy, ty < gy, tx > gx};
    rev_prev = rev_dir(prev);
    legal    = valid & ~rev_prev;
    cand     = legal & toward;
    if (((cand & H_MASK) != 4'b0000) && ((cand & V_MASK) != 4'b0000))
      normal_pick = (dx >= dy) ? (cand & H_MASK) : (cand & V_MASK);
    else if (cand != 4'b0000)
      normal_pick = cand;
    else
      normal_pick = first_prio(legal);
    dead_pick = ((valid & rev_prev) != 4'b0000) ? rev_prev : first_prio(valid);
  end

`ifdef GHOST_FRIGHT_MODE_EN
  logic [7:0] lfsr;
  logic       rev_pending, sweep_rev;
  logic [3:0] fright_pick;

  function automatic logic [3:0] scan_dir(input logic [1:0] s);
    case (s)
      2'd0:    return DIR_R;
      2'd1:    return DIR_L;
      2'd2:    return DIR_U;
      default: return DIR_D;
    endcase
  endfunction

  // Walk the scan backwards so the earliest legal entry from the LFSR start wins.
  always_comb begin
    fright_pick = 4'b0000;
    for (int k = 3; k >= 0; k--) begin
      if ((legal & scan_dir(lfsr[1:0] + 2'(k))) != 4'b0000)
        fright_pick = scan_dir(lfsr[1:0] + 2'(k));
    end
  end

  always_comb begin
    if (sweep_rev && ((valid & rev_prev) != 4'b0000)) pick = rev_prev;
    else if (legal == 4'b0000)                        pick = dead_pick;
    else if (sweep_mode == MODE_FRIGHT)               pick = fright_pick;
    else                                              pick = normal_pick;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr        <= 8'hA5;
      rev_pending <= 1'b0;
      sweep_rev   <= 1'b0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (sweep_start) sweep_rev <= rev_pending;
      if (power_pellet)     rev_pending <= 1'b1;
      else if (sweep_start) rev_pending <= 1'b0;
    end
  end
`else
  logic unused_pellet;
  assign unused_pellet = power_pellet;

  always_comb begin
    pick = (legal == 4'b0000) ? dead_pick : normal_pick;
  end
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      move_dir   <= '0;
      dir_valid  <= 1'b0;
      overrun    <= 1'b0;
      sweep_mode <= MODE_SCATTER;
    end else begin
      dir_valid <= (state == S_DONE);
      if (tick && (state != S_IDLE)) overrun <= 1'b1;
      if (sweep_start) begin
        idx        <= '0;
        sweep_mode <= mode_q;
      end else if (state == S_EVAL) begin
        move_dir[idx*4 +: 4] <= pick;
        idx                  <= idx + 1'b1;
      end
    end
  end

  always_comb begin
    mode_limit = TW'(SCATTER_TICKS - 1);
    mode_after = MODE_CHASE;
    case (mode_q)
      MODE_CHASE: begin
        mode_limit = TW'(CHASE_TICKS - 1);
        mode_after = MODE_SCATTER;
      end
      MODE_FRIGHT: begin
        mode_limit = TW'(FRIGHT_TICKS - 1);
        mode_after = MODE_CHASE;
      end
      default: ;
    endcase
  end

  // Mode timer counts every tick, including those that arrive mid-sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_SCATTER;
      timer  <= '0;
    end
`ifdef GHOST_FRIGHT_MODE_EN
    else if (power_pellet) begin
      mode_q <= MODE_FRIGHT;
      timer  <= '0;
    end
`endif
    else if (tick) begin
      if (timer == mode_limit) begin
        mode_q <= mode_after;
        timer  <= '0;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ghost_nav_scheduler.sv
// Bench for ghost_nav_scheduler: randomized and directed sweeps checked against a rule-level model
// of target selection, dead ends, mode timing and (with GHOST_FRIGHT_MODE_EN) pellet reversal.
module tb_ghost_nav_scheduler;

  localparam int NG    = 4;
  localparam int X_W   = 11;
  localparam int Y_W   = 10;
  localparam int X_MAX = 639;
  localparam int Y_MAX = 479;
`ifdef GHOST_FRIGHT_MODE_EN
  localparam bit FRIGHT_EN = 1'b1;
`else
  localparam bit FRIGHT_EN = 1'b0;
`endif

  localparam logic [3:0] R = 4'b0001;
  localparam logic [3:0] U = 4'b0010;
  localparam logic [3:0] D = 4'b0100;
  localparam logic [3:0] L = 4'b1000;

  logic                clk = 1'b0;
  logic                rst;
  logic                tick;
  logic [NG*X_W-1:0]   ghost_pos_x;
  logic [NG*Y_W-1:0]   ghost_pos_y;
  logic [X_W-1:0]      pacman_pos_x;
  logic [Y_W-1:0]      pacman_pos_y;
  logic [NG*4-1:0]     valid_moves;
  logic                power_pellet;
  logic [NG*4-1:0]     move_dir;
  logic                dir_valid;
  logic [1:0]          mode;
  logic                overrun;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  int         model_mode;
  int         model_cnt;
  bit         model_rev_pending;
  logic [3:0] model_prev [NG];
  bit         model_prev_known [NG];
  int         gx [NG];
  int         gy [NG];
  logic [3:0] gvalid [NG];
  int         pac_x, pac_y;

  ghost_nav_scheduler #(
    .NUM_GHOSTS(NG), .X_W(X_W), .Y_W(Y_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX),
    .SCATTER_TICKS(7), .CHASE_TICKS(20), .FRIGHT_TICKS(6)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .ghost_pos_x(ghost_pos_x), .ghost_pos_y(ghost_pos_y),
    .pacman_pos_x(pacman_pos_x), .pacman_pos_y(pacman_pos_y),
    .valid_moves(valid_moves), .power_pellet(power_pellet),
    .move_dir(move_dir), .dir_valid(dir_valid), .mode(mode), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] opposite(input logic [3:0] d);
    case (d)
      R:       return L;
      L:       return R;
      U:       return D;
      D:       return U;
      default: return 4'b0000;
    endcase
  endfunction

  // Among legal moves, prefer the one that closes the largest gap; ties go to the earlier of R,L,U,D.
  function automatic logic [3:0] model_move(input int gxi, input int gyi, input int txi, input int tyi,
                                            input logic [3:0] valid, input logic [3:0] prev);
    logic [3:0] order [4];
    logic [3:0] legal, best;
    int         score, best_score;
    order[0] = R; order[1] = L; order[2] = U; order[3] = D;
    legal = valid & ~opposite(prev);
    if (legal == 4'b0000) begin
      if ((valid & opposite(prev)) != 4'b0000) return opposite(prev);
      for (int k = 0; k < 4; k++)
        if ((valid & order[k]) != 4'b0000) return order[k];
      return 4'b0000;
    end
    best       = 4'b0000;
    best_score = -2;
    for (int k = 0; k < 4; k++) begin
      if ((legal & order[k]) != 4'b0000) begin
        case (order[k])
          R:       score = (txi > gxi) ? txi - gxi : -1;
          L:       score = (txi < gxi) ? gxi - txi : -1;
          U:       score = (tyi < gyi) ? gyi - tyi : -1;
          default: score = (tyi > gyi) ? tyi - gyi : -1;
        endcase
        if (score > best_score) begin
          best_score = score;
          best       = order[k];
        end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    model_mode        = 0;
    model_cnt         = 0;
    model_rev_pending = 1'b0;
    for (int i = 0; i < NG; i++) begin
      model_prev[i]       = 4'b0000;
      model_prev_known[i] = 1'b1;
    end
  endtask

  task automatic model_tick();
    int limit;
    int after;
    limit = (model_mode == 0) ? 7 : (model_mode == 1) ? 20 : 6;
    after = (model_mode == 1) ? 0 : 1;
    model_cnt++;
    if (model_cnt == limit) begin
      model_mode = after;
      model_cnt  = 0;
    end
  endtask

  function automatic int pick_coord(input int pac, input int max_v, input int w);
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return max_v;
      2:       return pac;
      default: return int'($urandom_range(0, (1 << w) - 1));
    endcase
  endfunction

  task automatic randomize_stim();
    pac_x = int'($urandom_range(0, (1 << X_W) - 1));
    pac_y = int'($urandom_range(0, (1 << Y_W) - 1));
    for (int i = 0; i < NG; i++) begin
      gx[i]     = pick_coord(pac_x, X_MAX, X_W);
      gy[i]     = pick_coord(pac_y, Y_MAX, Y_W);
      gvalid[i] = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic drive_stim();
    for (int i = 0; i < NG; i++) begin
      ghost_pos_x[i*X_W +: X_W] = X_W'(gx[i]);
      ghost_pos_y[i*Y_W +: Y_W] = Y_W'(gy[i]);
      valid_moves[i*4 +: 4]     = gvalid[i];
    end
    pacman_pos_x = X_W'(pac_x);
    pacman_pos_y = Y_W'(pac_y);
  endtask

  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) step();
    rst = 1'b0;
    model_reset();
    check("rst_move_dir", move_dir, 0);
    check("rst_dir_valid", dir_valid, 0);
    check("rst_mode", mode, 0);
    check("rst_overrun", overrun, 0);
  endtask

  // One full sweep: tick (optionally with pellet), per-slice latency checks, dir_valid pulse, mode.
  task automatic do_sweep(input bit pellet);
    logic [3:0] exp_dir [NG];
    bit         known [NG];
    int         smode, tx, ty;
    bit         use_rev;
    smode   = model_mode;
    use_rev = model_rev_pending;
    for (int i = 0; i < NG; i++) begin
      tx = (smode == 1) ? pac_x : (((i % 4) == 1 || (i % 4) == 3) ? X_MAX : 0);
      ty = (smode == 1) ? pac_y : (((i % 4) >= 2) ? Y_MAX : 0);
      known[i]   = model_prev_known[i];
      exp_dir[i] = 4'b0000;
      if (known[i] && use_rev && ((gvalid[i] & opposite(model_prev[i])) != 4'b0000))
        exp_dir[i] = opposite(model_prev[i]);
      else if (smode == 2)
        known[i] = 1'b0;
      else if (known[i])
        exp_dir[i] = model_move(gx[i], gy[i], tx, ty, gvalid[i], model_prev[i]);
    end

    drive_stim();
    check("pre_sweep_dir_valid", dir_valid, 0);
    power_pellet = pellet;
    tick         = 1'b1;
    step();
    tick         = 1'b0;
    power_pellet = 1'b0;
    model_rev_pending = 1'b0;
    if (pellet && FRIGHT_EN) begin
      model_mode        = 2;
      model_cnt         = 0;
      model_rev_pending = 1'b1;
    end else begin
      model_tick();
    end

    for (int i = 0; i < NG; i++) begin
      step();
      if (known[i]) check($sformatf("slice%0d", i), move_dir[i*4 +: 4], exp_dir[i]);
      if (i + 1 < NG && model_prev_known[i+1])
        check($sformatf("slice%0d_not_early", i + 1), move_dir[(i+1)*4 +: 4], model_prev[i+1]);
      check($sformatf("dir_valid_low_%0d", i), dir_valid, 0);
    end
    step();
    check("dir_valid_pulse", dir_valid, 1);
    check("sweep_mode_out", mode, 2'(model_mode));
    step();
    check("dir_valid_drop", dir_valid, 0);
    for (int i = 0; i < NG; i++) begin
      model_prev[i]       = exp_dir[i];
      model_prev_known[i] = known[i];
    end
  endtask

  initial begin
    int waited;
    rst          = 1'b1;
    tick         = 1'b0;
    power_pellet = 1'b0;
    ghost_pos_x  = '0;
    ghost_pos_y  = '0;
    pacman_pos_x = '0;
    pacman_pos_y = '0;
    valid_moves  = '0;
    model_reset();

    apply_reset(2);

    // SCATTER: seven ticks; the last leaves ghost0 heading UP for the CHASE cases below.
    for (int s = 0; s < 7; s++) begin
      randomize_stim();
      if (s == 6) gvalid[0] = U;
      do_sweep(1'b0);
    end
    check("mode_after_7_ticks", mode, 2'b01);

    randomize_stim();
    gx[0] = 100; gy[0] = 100; pac_x = 300; pac_y = 150; gvalid[0] = R | D | U;
    do_sweep(1'b0);
    check("chase_right", move_dir[3:0], R);

    randomize_stim();
    gvalid[0] = L;
    do_sweep(1'b0);
    check("dead_end_reverse", move_dir[3:0], L);

    randomize_stim();
    gvalid[0] = 4'b0000;
    do_sweep(1'b0);
    check("no_valid_moves", move_dir[3:0], 4'b0000);

    randomize_stim();
    gx[0] = 100; gy[0] = 100; pac_x = 200; pac_y = 200; gvalid[0] = R | D;
    do_sweep(1'b0);
    check("tie_goes_horizontal", move_dir[3:0], R);

    for (int s = 0; s < 16; s++) begin
      randomize_stim();
      do_sweep(1'b0);
    end
    check("mode_after_20_chase", mode, 2'b00);

    for (int s = 0; s < 3; s++) begin
      randomize_stim();
      do_sweep(1'b0);
    end

`ifdef GHOST_FRIGHT_MODE_EN
    randomize_stim();
    for (int i = 0; i < NG; i++) gvalid[i] = 4'hF;
    do_sweep(1'b0);
    randomize_stim();
    for (int i = 0; i < NG; i++) gvalid[i] = 4'hF;
    do_sweep(1'b1);
    check("pellet_to_fright", mode, 2'b10);
    randomize_stim();
    for (int i = 0; i < NG; i++) gvalid[i] = 4'hF;
    do_sweep(1'b0);
    for (int s = 0; s < 4; s++) begin
      randomize_stim();
      do_sweep(1'b0);
    end
    check("fright_after_5", mode, 2'b10);
    randomize_stim();
    do_sweep(1'b0);
    check("fright_to_chase", mode, 2'b01);
`else
    power_pellet = 1'b1;
    step();
    power_pellet = 1'b0;
    check("pellet_ignored", mode, 2'b00);
    randomize_stim();
    do_sweep(1'b1);
`endif

    // Overrun: a second tick while the sweep is running latches overrun until reset.
    apply_reset(2);
    randomize_stim();
    drive_stim();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    check("overrun_clear_before", overrun, 0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("overrun_set", overrun, 1);
    waited = 0;
    while (dir_valid !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    check("overrun_sweep_completes", dir_valid, 1);
    repeat (5) step();
    check("overrun_sticky", overrun, 1);

    // Reset mid-sweep aborts it: no dir_valid afterwards.
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    check("abort_move_dir", move_dir, 0);
    check("abort_overrun", overrun, 0);
    check("abort_mode", mode, 0);
    for (int c = 0; c < 8; c++) begin
      step();
      check("abort_no_dir_valid", dir_valid, 0);
    end

    randomize_stim();
    do_sweep(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
